// File: rtl/signal_deposit_sequencer_pkg.sv
// rtl/signal_deposit_sequencer_pkg.sv - shared types, constants and saturating helpers for the deposit sequencer
// Decay states exist only when SIGNAL_DECAY_EN is defined.
package signal_deposit_sequencer_pkg;

    localparam int ANT_bits     = 16;
    localparam int X_bits       = 8;
    localparam int Y_bits       = 8;
    localparam int SIGNAL_bits  = 4;
    localparam int SIGNAL_MAX   = (1 << SIGNAL_bits) - 1;
    localparam int ANT_SEL_bits = $clog2(ANT_bits);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECT,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
`ifdef SIGNAL_DECAY_EN
        ,
        S_DK_READ,
        S_DK_WAIT,
        S_DK_WRITE
`endif
    } state_e;

    function automatic logic [SIGNAL_bits-1:0] sat_add(input logic [SIGNAL_bits-1:0] a,
                                                       input logic [SIGNAL_bits-1:0] b);
        logic [SIGNAL_bits:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SIGNAL_bits] ? SIGNAL_bits'(SIGNAL_MAX) : s[SIGNAL_bits-1:0];
    endfunction

    function automatic logic [SIGNAL_bits-1:0] sat_sub(input logic [SIGNAL_bits-1:0] a,
                                                       input logic [SIGNAL_bits-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/signal_saturator.sv
// rtl/signal_saturator.sv - combinational saturating add/subtract shared by the deposit and decay writes
module signal_saturator #(
    parameter int W = 4
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] amount,
    input  logic         sub_mode,
    output logic [W-1:0] result
);

    logic [W:0] sum;

    // The carry out of the W+1 bit sum is the overflow indicator for the clamp.
    always_comb begin
        sum = {1'b0, value} + {1'b0, amount};
        if (sub_mode) begin
            result = (value > amount) ? (value - amount) : '0;
        end else begin
            result = sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/signal_deposit_sequencer.sv
// rtl/signal_deposit_sequencer.sv - walks all ants and deposits saturating trail signal into the shared map
// Optional decay sweep after the ant loop is enabled by defining SIGNAL_DECAY_EN.
module signal_deposit_sequencer #(
    parameter int N_ANTS      = 16,
    parameter int X_bits      = 8,
    parameter int Y_bits      = 8,
    parameter int SIGNAL_bits = 4,
    parameter int GRID_W      = 160,
    parameter int GRID_H      = 120,
    parameter int DEPOSIT     = 4,
    parameter int DECAY       = 1
) (
    input  logic                      Clk,
    input  logic                      RESET,
    input  logic                      start,
    output logic [$clog2(N_ANTS)-1:0] ant_sel,
    input  logic [X_bits-1:0]         ant_X,
    input  logic [Y_bits-1:0]         ant_Y,
    input  logic                      ant_mouthFull,
    output logic [X_bits+Y_bits-1:0]  mem_addr,
    output logic                      mem_rd_en,
    input  logic [SIGNAL_bits-1:0]    mem_rd_data,
    output logic                      mem_wr_en,
    output logic [SIGNAL_bits-1:0]    mem_wr_data,
    output logic                      busy,
    output logic                      global_writing_flag
);

    import signal_deposit_sequencer_pkg::*;

    localparam int SEL_W = $clog2(N_ANTS);
    localparam logic [SEL_W-1:0] LAST_ANT = SEL_W'(N_ANTS - 1);
`ifdef SIGNAL_DECAY_EN
    localparam state_e LOOP_EXIT = S_DK_READ;
`else
    localparam state_e LOOP_EXIT = S_DONE;
`endif

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [X_bits-1:0]      x_q, x_d;
    logic [Y_bits-1:0]      y_q, y_d;
    logic [SIGNAL_bits-1:0] val_q, val_d;
    logic                   flag_q, flag_d;
    logic                   advance;
    logic                   in_range;
    logic                   sub_mode;
    logic [SIGNAL_bits-1:0] sat_amount;
    logic [SIGNAL_bits-1:0] sat_result;

    assign in_range = ({1'b0, ant_X} < (X_bits+1)'(GRID_W)) &&
                      ({1'b0, ant_Y} < (Y_bits+1)'(GRID_H));
    assign sat_amount = sub_mode ? SIGNAL_bits'(DECAY) : SIGNAL_bits'(DEPOSIT);

    signal_saturator #(.W(SIGNAL_bits)) u_saturator (
        .value    (val_q),
        .amount   (sat_amount),
        .sub_mode (sub_mode),
        .result   (sat_result)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        x_d       = x_q;
        y_d       = y_q;
        val_d     = val_q;
        flag_d    = (state_q == S_DONE);
        advance   = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        sub_mode  = 1'b0;
        case (state_q)
            // The flag cycle is spent in IDLE, so a start coinciding with it is dropped here.
            S_IDLE: begin
                if (start && !flag_q) begin
                    sel_d   = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (ant_mouthFull && in_range) begin
                    x_d     = ant_X;
                    y_d     = ant_Y;
                    state_d = S_READ;
                end else begin
                    advance = 1'b1;
                end
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                val_d   = mem_rd_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en = 1'b1;
                advance   = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef SIGNAL_DECAY_EN
            S_DK_READ: begin
                mem_rd_en = 1'b1;
                state_d   = S_DK_WAIT;
            end
            S_DK_WAIT: begin
                val_d   = mem_rd_data;
                state_d = S_DK_WRITE;
            end
            S_DK_WRITE: begin
                mem_wr_en = 1'b1;
                sub_mode  = 1'b1;
                state_d   = S_DK_READ;
                if (x_q == X_bits'(GRID_W - 1)) begin
                    x_d = '0;
                    if (y_q == Y_bits'(GRID_H - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        y_d = y_q + Y_bits'(1);
                    end
                end else begin
                    x_d = x_q + X_bits'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (sel_q == LAST_ANT) begin
                state_d = LOOP_EXIT;
`ifdef SIGNAL_DECAY_EN
                x_d = '0;
                y_d = '0;
`endif
            end else begin
                sel_d   = sel_q + SEL_W'(1);
                state_d = S_SELECT;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            val_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            x_q     <= x_d;
            y_q     <= y_d;
            val_q   <= val_d;
            flag_q  <= flag_d;
        end
    end

    assign ant_sel             = sel_q;
    assign mem_addr            = {y_q, x_q};
    assign mem_wr_data         = mem_wr_en ? sat_result : '0;
    assign busy                = (state_q != S_IDLE) || flag_q;
    assign global_writing_flag = flag_q;

endmodule

// File: tb/tb_signal_deposit_sequencer.sv
// tb/tb_signal_deposit_sequencer.sv - directed and randomized checks of the deposit sequencer against a cell-level model
module tb_signal_deposit_sequencer;

    localparam int N   = 4;
    localparam int DEP = 4;
    localparam int DK  = 1;
`ifdef SIGNAL_DECAY_EN
    localparam int GW = 2, GH = 2, SWEEP = 3 * GW * GH;
`else
    localparam int GW = 160, GH = 120, SWEEP = 0;
`endif
    localparam int LIMIT = 2000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]  ant_sel;
    logic [7:0]  ant_X, ant_Y;
    logic        ant_mf;
    logic [15:0] mem_addr;
    logic        mem_rd_en, mem_wr_en, busy, flag;
    logic [3:0]  mem_rd_data = 4'd0, mem_wr_data;

    logic [7:0]  ax [N];
    logic [7:0]  ay [N];
    logic        af [N];
    logic [3:0]  mem [65536];
    logic [3:0]  pre [int];
    logic        bd_en = 1'b0;
    logic [15:0] bd_addr = 16'd0;
    logic [3:0]  bd_data = 4'd0;

    int n_cmp = 0, n_bad = 0;
    int rd_cnt = 0, wr_cnt = 0, flag_cnt = 0;
    logic [15:0] rd_addr_log [256];
    logic [15:0] wr_addr_log [256];
    logic [3:0]  wr_data_log [256];

    signal_deposit_sequencer #(
        .N_ANTS(N), .X_bits(8), .Y_bits(8), .SIGNAL_bits(4),
        .GRID_W(GW), .GRID_H(GH), .DEPOSIT(DEP), .DECAY(DK)
    ) dut (
        .Clk(clk), .RESET(rst), .start(start), .ant_sel(ant_sel),
        .ant_X(ant_X), .ant_Y(ant_Y), .ant_mouthFull(ant_mf),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .busy(busy), .global_writing_flag(flag)
    );

    always #5 clk = ~clk;

    assign ant_X  = ax[ant_sel];
    assign ant_Y  = ay[ant_sel];
    assign ant_mf = af[ant_sel];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
        if (bd_en) mem[bd_addr] = bd_data;
    end

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_addr_log[rd_cnt % 256] = mem_addr;
            rd_cnt = rd_cnt + 1;
        end
        if (mem_wr_en) begin
            wr_addr_log[wr_cnt % 256] = mem_addr;
            wr_data_log[wr_cnt % 256] = mem_wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (flag) flag_cnt = flag_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    task automatic preload();
        foreach (pre[a]) begin
            @(negedge clk);
            bd_addr = a[15:0];
            bd_data = pre[a];
            bd_en   = 1'b1;
        end
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    function automatic bit in_grid(input int x, input int y);
        return (x < GW) && (y < GH);
    endfunction

    // Runs one step on the current ant table and preloaded cells, checking against the cell model.
    task automatic do_step(input string tag, input int extra_start, input bit start_on_flag);
        logic [3:0] expm [int];
        int k, lat, rd0, wr0, fl0, c, v;
        expm = pre;
        k = 0;
        for (int i = 0; i < N; i++) begin
            if (af[i] && in_grid(int'(ax[i]), int'(ay[i]))) begin
                k++;
                v = int'(expm[int'(ay[i]) * 256 + int'(ax[i])]) + DEP;
                expm[int'(ay[i]) * 256 + int'(ax[i])] = (v > 15) ? 4'd15 : 4'(v);
            end
        end
`ifdef SIGNAL_DECAY_EN
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) begin
                v = int'(expm[y * 256 + x]) - DK;
                expm[y * 256 + x] = (v < 0) ? 4'd0 : 4'(v);
            end
`endif
        preload();
        rd0 = rd_cnt; wr0 = wr_cnt; fl0 = flag_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, ".busy_first"}, 32'(busy), 32'd1);
        lat = -1;
        for (c = 1; c <= LIMIT; c++) begin
            if (flag) begin
                lat = c;
                break;
            end
            start = (c == extra_start);
            @(negedge clk);
        end
        start = start_on_flag;
        chk({tag, ".latency"}, 32'(lat), 32'(2 + N + 3 * k + SWEEP));
        chk({tag, ".busy_at_flag"}, 32'(busy), 32'd1);
        @(negedge clk); start = 1'b0;
        chk({tag, ".flag_width"}, 32'(flag), 32'd0);
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, ".reads"}, 32'(rd_cnt - rd0), 32'(k + GW * GH * (SWEEP > 0 ? 1 : 0)));
        chk({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(k + GW * GH * (SWEEP > 0 ? 1 : 0)));
        chk({tag, ".flags"}, 32'(flag_cnt - fl0), 32'd1);
        foreach (expm[a]) chk({tag, ".cell"}, 32'(mem[a[15:0]]), 32'(expm[a]));
    endtask

    task automatic randomize_ants(input int maxx, input int maxy);
        pre.delete();
        for (int i = 0; i < N; i++) begin
            ax[i] = 8'($urandom_range(0, maxx));
            ay[i] = 8'($urandom_range(0, maxy));
            af[i] = 1'($urandom_range(0, 1));
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                ax[i] = ax[0];
                ay[i] = ay[0];
            end
            if (in_grid(int'(ax[i]), int'(ay[i])))
                pre[int'(ay[i]) * 256 + int'(ax[i])] = 4'($urandom_range(0, 15));
        end
`ifdef SIGNAL_DECAY_EN
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                pre[y * 256 + x] = 4'($urandom_range(0, 15));
`endif
    endtask

    initial begin
        int w0, f0;
        for (int i = 0; i < N; i++) begin ax[i] = 8'd0; ay[i] = 8'd0; af[i] = 1'b0; end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.ant_sel", 32'(ant_sel), 32'd0);
        chk("reset.mem_addr", 32'(mem_addr), 32'd0);
        chk("reset.rd_en", 32'(mem_rd_en), 32'd0);
        chk("reset.wr_en", 32'(mem_wr_en), 32'd0);
        chk("reset.wr_data", 32'(mem_wr_data), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.flag", 32'(flag), 32'd0);
        rst = 1'b0;
        @(negedge clk);

`ifndef SIGNAL_DECAY_EN
        pre.delete();
        for (int i = 0; i < N; i++) begin ax[i] = 8'(i); ay[i] = 8'(i); end
        do_step("idle_ants", 0, 1'b0);
        chk("sel_hold", 32'(ant_sel), 32'd3);

        pre.delete();
        ax[2] = 8'd5; ay[2] = 8'd3; af[2] = 1'b1;
        pre[3 * 256 + 5] = 4'd7;
        do_step("one_ant", 0, 1'b0);
        chk("one_ant.rd_addr", 32'(rd_addr_log[(rd_cnt - 1) % 256]), 32'h0305);
        chk("one_ant.wr_addr", 32'(wr_addr_log[(wr_cnt - 1) % 256]), 32'h0305);
        chk("one_ant.wr_data", 32'(wr_data_log[(wr_cnt - 1) % 256]), 32'd11);

        pre.delete();
        af[2] = 1'b0;
        ax[0] = 8'd10; ay[0] = 8'd10; af[0] = 1'b1;
        ax[1] = 8'd10; ay[1] = 8'd10; af[1] = 1'b1;
        pre[10 * 256 + 10] = 4'd13;
        do_step("same_cell", 0, 1'b0);
        chk("same_cell.wr0", 32'(wr_data_log[(wr_cnt - 2) % 256]), 32'd15);
        chk("same_cell.wr1", 32'(wr_data_log[(wr_cnt - 1) % 256]), 32'd15);

        pre.delete();
        ax[0] = 8'd160; ay[0] = 8'd0;
        ax[1] = 8'd0;   ay[1] = 8'd120;
        do_step("out_of_range", 2, 1'b1);
        chk("addr_hold", 32'(mem_addr), 32'h0a0a);
        af[0] = 1'b0;
`endif

        pre.delete();
        for (int i = 0; i < N; i++) begin ax[i] = 8'd0; ay[i] = 8'd0; af[i] = 1'b0; end
        ax[1] = 8'(GW - 1); ay[1] = 8'(GH - 1); af[1] = 1'b1;
        pre[(GH - 1) * 256 + (GW - 1)] = 4'd3;
        preload();
        w0 = wr_cnt; f0 = flag_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid.rd_en", 32'(mem_rd_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.ant_sel", 32'(ant_sel), 32'd0);
        chk("rst_mid.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mid.rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mid.wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.flag", 32'(flag), 32'd0);
        repeat (10) @(negedge clk);
        chk("rst_mid.no_write", 32'(wr_cnt - w0), 32'd0);
        chk("rst_mid.no_flag", 32'(flag_cnt - f0), 32'd0);
        chk("rst_mid.cell", 32'(mem[16'(((GH - 1) * 256) + (GW - 1))]), 32'd3);
        do_step("after_reset", 0, 1'b0);

`ifdef SIGNAL_DECAY_EN
        pre.delete();
        for (int i = 0; i < N; i++) af[i] = 1'b0;
        pre[0] = 4'd0; pre[1] = 4'd1; pre[256] = 4'd5; pre[257] = 4'd15;
        do_step("decay", 0, 1'b0);
        chk("decay.c00", 32'(mem[16'h0000]), 32'd0);
        chk("decay.c01", 32'(mem[16'h0001]), 32'd0);
        chk("decay.c10", 32'(mem[16'h0100]), 32'd4);
        chk("decay.c11", 32'(mem[16'h0101]), 32'd14);
`endif

        for (int s = 0; s < 20; s++) begin
            randomize_ants(GW + 10, GH + 10);
            do_step("random", int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
